// File: rtl/shift_pkg.sv
// Shared encodings for the multi-cycle shift unit: FSM states, per-cycle
// step size and shift direction codes.
package shift_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Largest shift distance applied in one cycle
  localparam int STEP_MAX = 2;

  localparam logic DIR_SLL = 1'b0;
  localparam logic DIR_SRL = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT,
    S_DONE  = ST_DONE
  } state_t;

endpackage

// File: rtl/shl2_stage.sv
// Combinational single-step shifter: moves the operand by 2 bits (sel2=1)
// or by 1 bit (sel2=0), zero-filling vacated positions.
// Optional feature macro: SHIFT_DIR_EN adds the dir input and a right-shift
// path; without it only left shifts exist in the netlist.
module shl2_stage
  import shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] din,
  input  logic             sel2,
`ifdef SHIFT_DIR_EN
  input  logic             dir,
`endif
  output logic [WIDTH-1:0] dout
);

  // Select step distance (and direction when enabled)
  always_comb begin
    dout = sel2 ? (din << 2) : (din << 1);
`ifdef SHIFT_DIR_EN
    if (dir == DIR_SRL) begin
      dout = sel2 ? (din >> 2) : (din >> 1);
    end
`endif
  end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle logical shift unit for the EX stage. Shifts by shamt, two bits
// per cycle with a single-bit final step for odd amounts, under a start/done
// handshake; busy stalls the pipeline while an operation is in flight.
// SHAMT_W must satisfy 2**SHAMT_W <= WIDTH.
// Optional feature macro: SHIFT_DIR_EN adds the dir port (0=SLL, 1=SRL).
module seq_shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
`ifdef SHIFT_DIR_EN
  input  logic               dir,
`endif
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   data_out
);

  localparam logic [SHAMT_W-1:0] STEP_CNT = SHAMT_W'(STEP_MAX);

  state_t             state_q, state_d;
  logic [SHAMT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0]   sreg_q,  sreg_d;
  logic [WIDTH-1:0]   dout_q,  dout_d;
  logic [WIDTH-1:0]   sh_out;
  logic               sel2;

  // Take a full 2-bit step unless only one bit of shift remains
  assign sel2 = (cnt_q >= STEP_CNT);

`ifdef SHIFT_DIR_EN
  logic dir_q, dir_d;

  shl2_stage #(.WIDTH(WIDTH)) u_step (
    .din  (sreg_q),
    .sel2 (sel2),
    .dir  (dir_q),
    .dout (sh_out)
  );
`else
  shl2_stage #(.WIDTH(WIDTH)) u_step (
    .din  (sreg_q),
    .sel2 (sel2),
    .dout (sh_out)
  );
`endif

  // State, counter, shift and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sreg_q  <= '0;
      dout_q  <= '0;
`ifdef SHIFT_DIR_EN
      dir_q   <= DIR_SLL;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
      dout_q  <= dout_d;
`ifdef SHIFT_DIR_EN
      dir_q   <= dir_d;
`endif
    end
  end

  // Next-state logic; the result register is loaded on entry to DONE so it
  // is valid while done is high and holds afterwards
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    dout_d  = dout_q;
`ifdef SHIFT_DIR_EN
    dir_d   = dir_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sreg_d = data_in;
          cnt_d  = shamt;
`ifdef SHIFT_DIR_EN
          dir_d  = dir;
`endif
          if (shamt == '0) begin
            state_d = S_DONE;
            dout_d  = data_in;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        sreg_d = sh_out;
        cnt_d  = sel2 ? (cnt_q - STEP_CNT) : '0;
        // Leaving when this step consumes the remaining count
        if (cnt_q <= STEP_CNT) begin
          state_d = S_DONE;
          dout_d  = sh_out;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy     = (state_q == S_SHIFT) || (state_q == S_DONE);
  assign done     = (state_q == S_DONE);
  assign data_out = dout_q;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Testbench for seq_shift_unit: directed cases (reset mid-operation, zero,
// odd and maximum shift, ignored start) followed by random operations
// checked against a shift-operator reference model.
module tb_seq_shift_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic        dir;
  logic        busy;
  logic        done;
  logic [31:0] data_out;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_shift_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .data_in  (data_in),
    .shamt    (shamt),
`ifdef SHIFT_DIR_EN
    .dir      (dir),
`endif
    .busy     (busy),
    .done     (done),
    .data_out (data_out)
  );

  function automatic logic [31:0] model_res(input logic [31:0] d, input int s, input logic dr);
    if (dr) return d >> s;
    return d << s;
  endfunction

  function automatic int model_lat(input int s);
    return (s + 1) / 2 + 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request at the negedge; returns 1 ns after the accept edge
  // (cycle 1) with the inputs scrambled to show they are not re-sampled.
  task automatic start_op(input logic [31:0] d, input logic [4:0] s, input logic dr);
    @(negedge clk);
    start   = 1'b1;
    data_in = d;
    shamt   = s;
    dir     = dr;
    @(posedge clk);
    #1;
    start   = 1'b0;
    data_in = $urandom;
    shamt   = 5'($urandom);
    dir     = ~dr;
  endtask

  // Walk cycles from k0 until done, bounded, then check latency and result
  task automatic wait_done(input int k0, input int exp_lat, input logic [31:0] exp_d,
                           input string tag);
    int k;
    k = k0;
    while (done !== 1'b1 && k < 40) begin
      chk({tag, "_busy_wait"}, 32'(busy), 32'd1);
      @(posedge clk);
      #1;
      k++;
    end
    chk({tag, "_latency"}, 32'(k), 32'(exp_lat));
    chk({tag, "_data"}, data_out, exp_d);
    chk({tag, "_busy_done"}, 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    chk({tag, "_done_clear"}, 32'(done), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_hold"}, data_out, exp_d);
  endtask

  initial begin
    logic [31:0] rd;
    logic [4:0]  rs;
    logic        rdir;
    int          pulses;

    rst     = 1'b1;
    start   = 1'b0;
    data_in = '0;
    shamt   = '0;
    dir     = 1'b0;
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_data", data_out, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Zero shift
    start_op(32'hDEADBEEF, 5'd0, 1'b0);
    wait_done(1, 1, 32'hDEADBEEF, "t2_zero");

    // Reset during SHIFT at cycle 3
    start_op(32'h1, 5'd9, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t1_busy_before", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_done", 32'(done), 32'd0);
    chk("t1_data", data_out, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done === 1'b1) pulses++;
    end
    chk("t1_no_done", 32'(pulses), 32'd0);
    chk("t1_idle", 32'(busy), 32'd0);

    // Odd shift with a start pulse during SHIFT that must be ignored
    start_op(32'h0000_0001, 5'd5, 1'b0);
    chk("t3_busy_c1", 32'(busy), 32'd1);
    @(negedge clk);
    start   = 1'b1;
    data_in = 32'h5;
    shamt   = 5'd1;
    @(posedge clk); #1;
    start   = 1'b0;
    wait_done(2, 4, 32'h0000_0020, "t3_odd");
    start_op(32'h5, 5'd1, 1'b0);
    wait_done(1, 2, 32'h0000_000A, "t5_after");

    // Maximum shift
    start_op(32'hFFFF_FFFF, 5'd31, 1'b0);
    wait_done(1, 17, 32'h8000_0000, "t4_max");

`ifdef SHIFT_DIR_EN
    start_op(32'h8000_0000, 5'd3, 1'b1);
    wait_done(1, 3, 32'h1000_0000, "t6_srl");
`endif

    // Random operations, mostly back-to-back with occasional idle gaps
    for (int i = 0; i < 2000; i++) begin
      rd = $urandom;
      rs = 5'($urandom_range(0, 31));
      rdir = 1'b0;
`ifdef SHIFT_DIR_EN
      rdir = 1'($urandom_range(0, 1));
`endif
      if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      start_op(rd, rs, rdir);
      wait_done(1, model_lat(int'(rs)), model_res(rd, int'(rs), rdir), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
